// File: rtl/tlc_multi_phase.sv
// tlc_multi_phase: N-approach round-robin traffic light controller.
//
// Serves one approach at a time through GREEN -> YELLOW -> ALL-RED. Vehicle
// demand is latched per approach. Green is held for at least T_GREEN_MIN
// cycles. It is extended while the served approach still detects vehicles,
// up to T_GREEN_MAX cycles. With no competing demand, green rests
// indefinitely. All outputs are registered.
//
// Optional feature: define TLC_PREEMPT_EN to add emergency preemption ports.
//
// Ports:
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_vd             vehicle detect, one bit per approach
//   o_red            red lamp per approach
//   o_yellow         yellow lamp per approach
//   o_green          green lamp per approach
//   o_phase          approach currently / most recently served
//   o_count          cycles spent in current state (saturating)
//   i_preempt        (TLC_PREEMPT_EN) preemption request
//   i_preempt_phase  (TLC_PREEMPT_EN) approach to preempt to

module tlc_multi_phase #(
    parameter int unsigned N_APPROACH  = 4,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned T_GREEN_MIN = 8,
    parameter int unsigned T_GREEN_MAX = 20,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2,
    localparam int unsigned PH_W = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_APPROACH-1:0] i_vd,
    output logic [N_APPROACH-1:0] o_red,
    output logic [N_APPROACH-1:0] o_yellow,
    output logic [N_APPROACH-1:0] o_green,
    output logic [PH_W-1:0]       o_phase,
    output logic [CNT_W-1:0]      o_count
`ifdef TLC_PREEMPT_EN
    ,
    input  logic                  i_preempt,
    input  logic [PH_W-1:0]       i_preempt_phase
`endif
);

    typedef enum logic [1:0] {
        StAllRed = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [PH_W-1:0]         next_q, next_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [N_APPROACH-1:0]   dem_q, dem_d;
    logic [N_APPROACH-1:0]   red_q, red_d;
    logic [N_APPROACH-1:0]   yellow_q, yellow_d;
    logic [N_APPROACH-1:0]   green_q, green_d;

    logic [N_APPROACH-1:0]   phase_oh;
    logic [N_APPROACH-1:0]   next_oh;
    logic [N_APPROACH-1:0]   out_oh;
    logic                    other_dem;
    logic                    served_vd;
    logic                    green_done;
    logic                    rr_found;
    logic [PH_W-1:0]         rr_next;
    logic                    pre_act;
    logic                    pre_hit;
    logic [PH_W-1:0]         pre_phase;
    logic                    entering_green;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StAllRed;
            phase_q  <= '0;
            next_q   <= '0;
            count_q  <= '0;
            dem_q    <= '0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            next_q   <= next_d;
            count_q  <= count_d;
            dem_q    <= dem_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    // Next-state logic
    always_comb begin
        phase_oh          = '0;
        phase_oh[phase_q] = 1'b1;
        next_oh           = '0;
        next_oh[next_q]   = 1'b1;

        other_dem  = |(dem_q & ~phase_oh);
        served_vd  = |(i_vd & phase_oh);
        green_done = (count_q >= GMIN_LAST) && other_dem &&
                     (!served_vd || (count_q >= GMAX_LAST));

        // Round-robin scan starting just after the served approach
        rr_found = 1'b0;
        rr_next  = phase_q;
        for (int unsigned k = 1; k < N_APPROACH; k++) begin
            int unsigned idx;
            idx = (32'(phase_q) + k) % N_APPROACH;
            if (!rr_found && dem_q[idx]) begin
                rr_found = 1'b1;
                rr_next  = PH_W'(idx);
            end
        end

`ifdef TLC_PREEMPT_EN
        // Out-of-range targets are ignored entirely
        pre_act   = i_preempt &&
                    ({1'b0, i_preempt_phase} < (PH_W + 1)'(N_APPROACH));
        pre_phase = i_preempt_phase;
`else
        pre_act   = 1'b0;
        pre_phase = '0;
`endif
        pre_hit = pre_act && (phase_q == pre_phase);

        state_d = state_q;
        phase_d = phase_q;
        next_d  = next_q;

        unique case (state_q)
            StGreen: begin
                if (pre_act) begin
                    if (!pre_hit) state_d = StYellow;
                end else if (green_done) begin
                    state_d = StYellow;
                    next_d  = rr_next;
                end
            end
            StYellow: begin
                if (count_q >= Y_LAST) state_d = StAllRed;
            end
            StAllRed: begin
                if (count_q >= AR_LAST) begin
                    state_d = StGreen;
                    phase_d = next_q;
                end
            end
            default: state_d = StAllRed;
        endcase

        if (pre_act) next_d = pre_phase;

        // Clear on green entry beats a same-cycle set
        entering_green = (state_q == StAllRed) && (state_d == StGreen);
        dem_d = (dem_q | (i_vd & ~((state_q == StGreen) ? phase_oh : '0))) &
                ~(entering_green ? next_oh : '0);

        if (state_d != state_q) begin
            count_d = '0;
        end else if (count_q == CNT_MAX) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Output decode, computed from the next state so lamps stay registered
    always_comb begin
        out_oh          = '0;
        out_oh[phase_d] = 1'b1;
        red_d           = '1;
        yellow_d        = '0;
        green_d         = '0;
        unique case (state_d)
            StGreen: begin
                green_d = out_oh;
                red_d   = ~out_oh;
            end
            StYellow: begin
                yellow_d = out_oh;
                red_d    = ~out_oh;
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    assign o_red    = red_q;
    assign o_yellow = yellow_q;
    assign o_green  = green_q;
    assign o_phase  = phase_q;
    assign o_count  = count_q;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Bench for tlc_multi_phase: directed scenarios with literal expectations plus
// randomized detector traffic checked every cycle against a behavioural model.
module tb_tlc_multi_phase;

    localparam int N    = 4;
    localparam int GMIN = 8;
    localparam int GMAX = 20;
    localparam int TY   = 3;
    localparam int TAR  = 2;
    localparam int CMAX = 63;

    logic       clk;
    logic       rst_n;
    logic [3:0] vd;
    logic [3:0] red, yellow, green;
    logic [1:0] phase;
    logic [5:0] count;
`ifdef TLC_PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_phase;
`endif

    tlc_multi_phase dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_vd     (vd),
        .o_red    (red),
        .o_yellow (yellow),
        .o_green  (green),
        .o_phase  (phase),
        .o_count  (count)
`ifdef TLC_PREEMPT_EN
        ,
        .i_preempt       (preempt),
        .i_preempt_phase (preempt_phase)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit model_on    = 1'b1;

    // Model: 0 = all-red, 1 = green, 2 = yellow
    int       m_st, m_ph, m_nx, m_cnt;
    bit [3:0] m_dem;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_nx = 0; m_cnt = 0; m_dem = '0;
    endtask

    task automatic model_step(input bit [3:0] v);
        int  n_st, n_ph, n_nx;
        bit  other;
        n_st = m_st; n_ph = m_ph; n_nx = m_nx;
        if (m_st == 1) begin
            other = 1'b0;
            for (int j = 0; j < N; j++) if (j != m_ph && m_dem[j]) other = 1'b1;
            if (m_cnt >= GMIN - 1 && other && (!v[m_ph] || m_cnt >= GMAX - 1)) begin
                n_st = 2;
                for (int k = N - 1; k >= 1; k--)
                    if (m_dem[(m_ph + k) % N]) n_nx = (m_ph + k) % N;
            end
        end else if (m_st == 2) begin
            if (m_cnt >= TY - 1) n_st = 0;
        end else begin
            if (m_cnt >= TAR - 1) begin
                n_st = 1;
                n_ph = m_nx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && !(m_st == 1 && m_ph == i)) m_dem[i] = 1'b1;
            if (m_st == 0 && n_st == 1 && m_nx == i) m_dem[i] = 1'b0;
        end
        m_cnt = (n_st != m_st) ? 0 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        m_st = n_st; m_ph = n_ph; m_nx = n_nx;
    endtask

    task automatic model_cmp();
        int eg, ey, er;
        if (!model_on) return;
        eg = (m_st == 1) ? (1 << m_ph) : 0;
        ey = (m_st == 2) ? (1 << m_ph) : 0;
        er = (m_st == 0) ? 15 : (~(1 << m_ph) & 15);
        chk("red", int'(red), er);
        chk("yellow", int'(yellow), ey);
        chk("green", int'(green), eg);
        chk("phase", int'(phase), m_ph);
        chk("count", int'(count), m_cnt);
        chk("demand", int'(dut.dem_q), int'(m_dem));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic tick(input logic [3:0] v);
        vd = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
        model_cmp();
    endtask

    // Counts cycles spent showing the given green/yellow pattern
    task automatic wait_leave(input logic [3:0] g, input logic [3:0] y,
                              input logic [3:0] v, output int n);
        n = 0;
        while (green == g && yellow == y) begin
            if (n > 200) begin
                chk("state_timeout", n, 0);
                break;
            end
            n++;
            tick(v);
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must settle before the next edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_red", int'(red), 15);
        chk("rst_yellow", int'(yellow), 0);
        chk("rst_green", int'(green), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_dem", int'(dut.dem_q), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_cmp();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        vd    = '0;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = '0;
`endif
        model_reset();
        @(negedge clk);

        // Reset release with no traffic: two all-red cycles then green0 rests
        do_reset();
        tick(4'b0000);
        chk("init_allred", int'(red), 15);
        tick(4'b0000);
        chk("init_green0", int'(green), 1);
        for (int i = 0; i < 100; i++) tick(4'b0000);
        chk("rest_green0", int'(green), 1);
        chk("rest_sat", int'(count), 63);

        // Max-out: served approach keeps detecting
        do_reset();
        tick(4'b0000); tick(4'b0000);
        tick(4'b0011);
        wait_leave(4'b0001, 4'b0000, 4'b0001, n);
        chk("maxout_len", 1 + n, 20);

        // Gap-out at o_count=12
        do_reset();
        tick(4'b0000); tick(4'b0000);
        tick(4'b0011);
        n = 0;
        while (count < 12 && n < 40) begin tick(4'b0001); n++; end
        chk("gap_count", int'(count), 12);
        tick(4'b0000);
        chk("gap_yellow", int'(yellow), 1);

        // Single pulse on approach 2 skips 1 and 3
        do_reset();
        tick(4'b0000); tick(4'b0000);
        tick(4'b0000); tick(4'b0000); tick(4'b0000);
        tick(4'b0100);
        wait_leave(4'b0001, 4'b0000, 4'b0000, n);
        chk("green0_len", 4 + n, 8);
        wait_leave(4'b0000, 4'b0001, 4'b0000, n);
        chk("yellow0_len", n, 3);
        wait_leave(4'b0000, 4'b0000, 4'b0000, n);
        chk("allred_len", n, 2);
        chk("green2", int'(green), 4);
        chk("phase2", int'(phase), 2);

        // Demand on 0 and 3 while green2: order 3 then 0
        tick(4'b1001);
        wait_leave(4'b0100, 4'b0000, 4'b0000, n);
        wait_leave(4'b0000, 4'b0100, 4'b0000, n);
        wait_leave(4'b0000, 4'b0000, 4'b0000, n);
        chk("green3", int'(green), 8);
        chk("dem3_clr", int'(dut.dem_q[3]), 0);
        chk("dem0_held", int'(dut.dem_q[0]), 1);
        wait_leave(4'b1000, 4'b0000, 4'b0000, n);
        wait_leave(4'b0000, 4'b1000, 4'b0000, n);
        wait_leave(4'b0000, 4'b0000, 4'b0000, n);
        chk("green0_after3", int'(green), 1);
        chk("dem0_clr", int'(dut.dem_q[0]), 0);

        // Async reset at o_count=1 of yellow
        tick(4'b0010);
        wait_leave(4'b0001, 4'b0000, 4'b0000, n);
        tick(4'b0000);
        chk("yellow_cnt1", int'(count), 1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] v;
            v = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick(v);
        end

`ifdef TLC_PREEMPT_EN
        // Preempt to approach 1 at o_count=2 of green0
        model_on = 1'b0;
        do_reset();
        tick(4'b0000); tick(4'b0000);
        tick(4'b0000); tick(4'b0000);
        chk("pre_cnt2", int'(count), 2);
        preempt       = 1'b1;
        preempt_phase = 2'd1;
        tick(4'b0000);
        chk("pre_yellow0", int'(yellow), 1);
        wait_leave(4'b0000, 4'b0001, 4'b0000, n);
        chk("pre_yellow_len", n, 3);
        wait_leave(4'b0000, 4'b0000, 4'b0000, n);
        chk("pre_allred_len", n, 2);
        chk("pre_green1", int'(green), 2);
        for (int i = 0; i < 30; i++) tick(4'b1101);
        chk("pre_hold", int'(green), 2);
        preempt = 1'b0;
        model_on = 1'b1;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlc_multi_phase.md
# tlc_multi_phase

Parametrised N-approach traffic light controller, successor to the fixed two-approach NS/EW controller. Sequences one green phase at a time through GREEN → YELLOW → ALL-RED, serving approaches in round-robin order based on latched vehicle demand. Applies minimum and maximum green limits, with green extension while the served approach still detects vehicles. Sits between the vehicle-detector inputs and the lamp drivers.

## Interface
- N_APPROACH, 4, number of approaches/phases, legal range 2..8.
- CNT_W, 6, width of the dwell counter.
- T_GREEN_MIN, 8, minimum green length in cycles.
- T_GREEN_MAX, 20, maximum green length in cycles when other demand exists.
- T_YELLOW, 3, yellow length in cycles.
- T_ALLRED, 2, all-red clearance length in cycles.
- Parameter rules: every T_* is ≥1 and ≤2^CNT_W−1; T_GREEN_MAX ≥ T_GREEN_MIN.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_vd  in  N_APPROACH  vehicle detect, one bit per approach, synchronous to i_clk.
- o_red  out  N_APPROACH  red lamp per approach.
- o_yellow  out  N_APPROACH  yellow lamp per approach.
- o_green  out  N_APPROACH  green lamp per approach.
- o_phase  out  max(1,$clog2(N_APPROACH))  approach currently or most recently served.
- o_count  out  CNT_W  cycles spent in the current state.

## Operation
- States: ALLRED, GREEN, YELLOW. All outputs are registered, so lamps are a Moore decode of the state register.
- GREEN: o_green[o_phase]=1; every other approach shows red.
- YELLOW: o_yellow[o_phase]=1; every other approach shows red.
- ALLRED: o_red is all ones.
- At any instant, at most one bit of o_green|o_yellow is set.
- Demand latch r_dem[i]:
  - Set when i_vd[i]=1, except while approach i is in GREEN.
  - Cleared on entry to GREEN for approach i.
  - If set and clear occur in the same cycle, clear wins.
- Other demand: any r_dem[j]=1 with j≠o_phase.
- GREEN exit condition, evaluated on o_count:
  - o_count ≥ T_GREEN_MIN−1, and
  - other demand exists, and
  - either i_vd[o_phase]=0 (gap-out) or o_count ≥ T_GREEN_MAX−1 (max-out).
- With no other demand, GREEN rests indefinitely.
- Next-phase selection: on the GREEN→YELLOW edge, r_next captures the first j with r_dem[j]=1, scanning o_phase+1, o_phase+2, … modulo N_APPROACH.
- YELLOW → ALLRED after T_YELLOW cycles.
- ALLRED → GREEN after T_ALLRED cycles. On that edge, o_phase takes r_next.
- Demand on the just-served approach arriving during YELLOW or ALLRED is latched and served in its round-robin turn.

## Timing
- o_count is 0 on the first cycle of each state and increments by 1 per cycle.
  - Saturates at 2^CNT_W−1; never wraps.
  - Returns to 0 on every state change.
- State change occurs on the clock edge after the exit condition is true. Consequently:
  - YELLOW lasts exactly T_YELLOW cycles.
  - ALLRED lasts exactly T_ALLRED cycles.
  - GREEN lasts between T_GREEN_MIN and T_GREEN_MAX cycles when demand is present at its entry.
- Detector-to-lamp latency: i_vd[j] sampled at edge k sets r_dem[j] at edge k. That demand can first satisfy the exit condition at edge k+1.
- Reset (i_rst_n=0) takes effect immediately, without waiting for a clock edge, including mid-state. Reset values:
  - state=ALLRED, o_red all ones.
  - o_yellow=0, o_green=0.
  - o_phase=0, r_next=0, o_count=0, r_dem=0.
- First cycle after reset release: ALLRED runs for T_ALLRED cycles, then approach 0 goes GREEN.

## Configuration
- TLC_PREEMPT_EN defined: adds the following input ports.
  - i_preempt  in  1.
  - i_preempt_phase  in  width of o_phase.
- Preemption behaviour while i_preempt=1:
  - GREEN on a phase ≠ i_preempt_phase goes to YELLOW on the next edge, ignoring T_GREEN_MIN.
  - r_next is forced to i_preempt_phase; a YELLOW or ALLRED already in progress completes normally.
  - GREEN on i_preempt_phase holds indefinitely.
  - On release, normal rules resume with o_count continuing.
  - An out-of-range i_preempt_phase is ignored.
- TLC_PREEMPT_EN undefined: the ports do not exist, and behaviour is exactly as described above.

## Test plan
Defaults for all scenarios: N_APPROACH=4, CNT_W=6, T_GREEN_MIN=8, T_GREEN_MAX=20, T_YELLOW=3, T_ALLRED=2.
- Reset, then release with i_vd=0 → ALLRED for 2 cycles, then o_green=4'b0001; green holds for 100 cycles with o_count saturated at 63.
- One pulse on i_vd[2] at o_count=3 of green0 → green0 lasts 8 cycles, then yellow0 for 3, all-red for 2, then o_green=4'b0100 and o_phase=2; approaches 1 and 3 are skipped.
- i_vd[0] held high, with a pulse on i_vd[1] → green0 lasts 20 cycles (max-out). If i_vd[0] drops at o_count=12, green0 ends after 13 cycles.
- Green on phase 2, r_dem[0] and r_dem[3] latched → service order is 3 then 0; both latches are cleared on their respective green entries.
- Asynchronous reset asserted at o_count=1 of yellow → outputs at reset values before the next edge; r_dem=0.
- With TLC_PREEMPT_EN: i_preempt=1 and i_preempt_phase=1 at o_count=2 of green0 → yellow0 on the next edge, then all-red for 2 cycles, then green1 held until i_preempt=0.
